// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request classification helpers
// for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] DM_B  = 3'b000;
   localparam logic [2:0] DM_H  = 3'b001;
   localparam logic [2:0] DM_W  = 3'b010;
   localparam logic [2:0] DM_BU = 3'b100;
   localparam logic [2:0] DM_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      SINGLE,
      SPLIT,
      DONE
   } lsu_state_e;

   // Bytes never misalign; halfwords need addr[0]=0, words addr[1:0]=00.
   function automatic logic is_aligned(input logic [2:0] ctrl, input logic [1:0] addrLow);
      case (ctrl)
         DM_H, DM_HU: is_aligned = ~addrLow[0];
         DM_W:        is_aligned = (addrLow == 2'b00);
         default:     is_aligned = 1'b1;
      endcase
   endfunction

   function automatic logic is_legal(input logic we, input logic [2:0] ctrl);
      case (ctrl)
         DM_B, DM_H, DM_W: is_legal = 1'b1;
         DM_BU, DM_HU:     is_legal = ~we;
         default:          is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] split_last(input logic [2:0] ctrl);
      split_last = (ctrl == DM_W) ? 2'd3 : 2'd1;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the data-memory initiator port.
// master = core and memory side, slave = load/store unit.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_ctrl;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [2:0]  mem_dm_ctrl;
   logic [31:0] mem_read_data;

   modport master (
      output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_read_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error,
      input  mem_address, mem_write_data, mem_write_enable, mem_dm_ctrl
   );

   modport slave (
      input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_read_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_error,
      output mem_address, mem_write_data, mem_write_enable, mem_dm_ctrl
   );
endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of a halfword assembled from split byte loads;
// words and anything else pass through untouched.
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [2:0]  ctrl_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (ctrl_i)
         DM_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
         DM_HU:   data_o = {16'h0000, data_i[15:0]};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, aligned accesses in one memory cycle.
// Define LSU_MISALIGNED_EN to split misaligned H/HU/W into byte accesses.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   lsu_if.slave bus
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;
   logic        split_q, split_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] extData;

   lsu_extend u_extend (
      .data_i (rdata_q),
      .ctrl_i (ctrl_q),
      .data_o (extData)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         ctrl_q  <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         error_q <= 1'b0;
         split_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         ctrl_q  <= ctrl_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         split_q <= split_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      ctrl_d  = ctrl_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      error_d = error_q;
      split_d = split_q;
      count_d = count_q;

      bus.req_ready        = 1'b0;
      bus.rsp_valid        = 1'b0;
      bus.rsp_error        = 1'b0;
      bus.rsp_rdata        = 32'h0;
      bus.mem_address      = 32'h0;
      bus.mem_write_data   = 32'h0;
      bus.mem_write_enable = 1'b0;
      bus.mem_dm_ctrl      = DM_W;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               ctrl_d  = bus.req_ctrl;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               rdata_d = 32'h0;
               count_d = 2'd0;
               split_d = 1'b0;
               error_d = 1'b0;
               if (!is_legal(bus.req_we, bus.req_ctrl)) begin
                  error_d = 1'b1;
                  state_d = DONE;
               end else if (is_aligned(bus.req_ctrl, bus.req_addr[1:0])) begin
                  state_d = SINGLE;
               end else begin
`ifdef LSU_MISALIGNED_EN
                  split_d = 1'b1;
                  state_d = SPLIT;
`else
                  error_d = 1'b1;
                  state_d = DONE;
`endif
               end
            end
         end
         SINGLE: begin
            bus.mem_address      = addr_q;
            bus.mem_write_data   = wdata_q;
            bus.mem_write_enable = we_q;
            bus.mem_dm_ctrl      = ctrl_q;
            if (!we_q) rdata_d = bus.mem_read_data;
            state_d = DONE;
         end
`ifdef LSU_MISALIGNED_EN
         // Byte i of the split goes to base+i; loads fill byte lane i little-endian.
         SPLIT: begin
            bus.mem_address      = addr_q + {30'h0, count_q};
            bus.mem_write_data   = {24'h0, wdata_q[{count_q, 3'b000} +: 8]};
            bus.mem_write_enable = we_q;
            bus.mem_dm_ctrl      = we_q ? DM_B : DM_BU;
            if (!we_q) rdata_d[{count_q, 3'b000} +: 8] = bus.mem_read_data[7:0];
            if (count_q == split_last(ctrl_q)) state_d = DONE;
            else count_d = count_q + 2'd1;
         end
`endif
         DONE: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_error = error_q;
            if (!error_q && !we_q) bus.rsp_rdata = split_q ? extData : rdata_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset silences the memory port in the same cycle so an abandoned
      // request cannot land one more write on the reset edge.
      if (rst) begin
         bus.req_ready        = 1'b1;
         bus.rsp_valid        = 1'b0;
         bus.rsp_error        = 1'b0;
         bus.rsp_rdata        = 32'h0;
         bus.mem_address      = 32'h0;
         bus.mem_write_data   = 32'h0;
         bus.mem_write_enable = 1'b0;
         bus.mem_dm_ctrl      = DM_W;
      end
   end

endmodule
